// File: rtl/vga_pkg.sv
// Shared display constants for the pong pipeline: default VGA timing, colours, screen size
// and the sync/active bundle carried between the timing decode and the pins.
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned SCREEN_W = H_ACTIVE;
    localparam int unsigned SCREEN_H = V_ACTIVE;

    typedef logic [11:0] rgb_t;

    localparam rgb_t COL_BLACK = 12'h000;
    localparam rgb_t COL_BLUE  = 12'h00F;
    localparam rgb_t COL_GREEN = 12'h0F0;
    localparam rgb_t COL_WHITE = 12'hFFF;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } vga_sync_t;

    // Inclusive window test; an empty window (hi < lo) never matches.
    function automatic logic in_win(logic [CNT_W-1:0] v, int unsigned lo, int unsigned hi);
        return (32'(v) >= lo) && (32'(v) <= hi);
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Enabled wrap-around counter 0..MAX with a combinational carry on the wrapping cycle;
// the next value is exported so callers can register decodes aligned with the count.
module vga_wrap_counter
    import vga_pkg::*;
#(
    parameter int unsigned MAX     = 799,
    parameter int unsigned RST_VAL = MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next_c,
    output logic             carry_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        carry_c = 1'b0;
        if (en) begin
            if (count_q == CNT_W'(MAX)) begin
                count_d = '0;
                carry_c = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= CNT_W'(RST_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign count        = count_q;
    assign count_next_c = count_d;

endmodule

// File: rtl/vga_timing_pong.sv
// VGA raster timing for the pong display: pixel divider, h/v scan counters, registered sync decode.
// Define VGA_TIMING_ALIGN_EN to delay hsync/vsync/activevideo one clk behind the coordinates.
module vga_timing_pong #(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CLK_DIV  = 1
) (
    input  logic                      clk,
    input  logic                      clr,
    output logic [vga_pkg::CNT_W-1:0] x_px,
    output logic [vga_pkg::CNT_W-1:0] y_px,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      activevideo,
    output logic                      px_tick,
    output logic                      line_start,
    output logic                      frame_start
);

    import vga_pkg::*;

    localparam int unsigned H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
    localparam int unsigned HS_HI   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
    localparam int unsigned VS_HI   = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DIV_MAX = (CLK_DIV > 1) ? CLK_DIV - 1 : 0;

    localparam vga_sync_t SYNC_RST = '{hsync: !SYNC_POL, vsync: !SYNC_POL, active: 1'b0};

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
        $error("vga_timing_pong: raster totals must not exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_pong: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_c;

    logic [CNT_W-1:0] h_next_c;
    logic [CNT_W-1:0] v_next_c;
    logic             h_carry_c;
    logic             v_carry_c;

    vga_sync_t sync_q;
    vga_sync_t sync_d;
    vga_sync_t sync_out;

    logic px_tick_q;
    logic px_tick_d;
    logic line_start_q;
    logic line_start_d;
    logic frame_start_q;
    logic frame_start_d;

    assign tick_c = (div_q == DIV_W'(DIV_MAX));

    vga_wrap_counter #(
        .MAX     (H_TOT - 1),
        .RST_VAL (H_TOT - 1)
    ) u_h_cnt (
        .clk          (clk),
        .rst          (clr),
        .en           (tick_c),
        .count        (x_px),
        .count_next_c (h_next_c),
        .carry_c      (h_carry_c)
    );

    vga_wrap_counter #(
        .MAX     (V_TOT - 1),
        .RST_VAL (V_TOT - 1)
    ) u_v_cnt (
        .clk          (clk),
        .rst          (clr),
        .en           (h_carry_c),
        .count        (y_px),
        .count_next_c (v_next_c),
        .carry_c      (v_carry_c)
    );

    // Decode from the counters' next values so the registered flags line up with x_px/y_px.
    always_comb begin
        div_d         = tick_c ? '0 : div_q + DIV_W'(1);
        sync_d        = SYNC_RST;
        sync_d.hsync  = in_win(h_next_c, HS_LO, HS_HI) ? SYNC_POL : !SYNC_POL;
        sync_d.vsync  = in_win(v_next_c, VS_LO, VS_HI) ? SYNC_POL : !SYNC_POL;
        sync_d.active = (32'(h_next_c) < H_ACTIVE) && (32'(v_next_c) < V_ACTIVE);
        px_tick_d     = tick_c;
        line_start_d  = h_carry_c;
        frame_start_d = h_carry_c && v_carry_c;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_q         <= '0;
            sync_q        <= SYNC_RST;
            px_tick_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            sync_q        <= sync_d;
            px_tick_q     <= px_tick_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_ALIGN_EN
    // Extra stage matches the renderer's registered colour output.
    vga_sync_t sync_dly_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_dly_q <= SYNC_RST;
        end else begin
            sync_dly_q <= sync_q;
        end
    end

    assign sync_out = sync_dly_q;
`else
    assign sync_out = sync_q;
`endif

    assign hsync       = sync_out.hsync;
    assign vsync       = sync_out.vsync;
    assign activevideo = sync_out.active;
    assign px_tick     = px_tick_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_pong.sv
// Scoreboard bench for vga_timing_pong: two shrunken rasters (CLK_DIV 1/active-low, CLK_DIV 3/active-high)
// under random asynchronous resets, checked against a pixel-index reference model.
module tb_vga_timing_pong;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int DA = 1, DB = 3;
    localparam bit PA = 1'b0, PB = 1'b1;
    localparam int N_CYCLES = 6000;

    typedef struct packed {
        int x;
        int y;
        bit hs;
        bit vs;
        bit av;
        bit tick;
        bit ls;
        bit fs;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b0;

    logic [9:0] xa, ya, xb, yb;
    logic hsa, vsa, ava, tka, lsa, fsa;
    logic hsb, vsb, avb, tkb, lsb, fsb;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;
    int pops = 0;
    int n = 0;

    always #5 clk = ~clk;

    vga_timing_pong #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(PA), .CLK_DIV(DA)
    ) dut_a (
        .clk(clk), .clr(clr), .x_px(xa), .y_px(ya), .hsync(hsa), .vsync(vsa),
        .activevideo(ava), .px_tick(tka), .line_start(lsa), .frame_start(fsa)
    );

    vga_timing_pong #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(PB), .CLK_DIV(DB)
    ) dut_b (
        .clk(clk), .clr(clr), .x_px(xb), .y_px(yb), .hsync(hsb), .vsync(vsb),
        .activevideo(avb), .px_tick(tkb), .line_start(lsb), .frame_start(fsb)
    );

    // Raster position after e clocks out of reset: pixel p = e/d, position p-1 in the frame, (HT-1,VT-1) before any pixel.
    function automatic void raster_pos(input int e, input int d, output int x, output int y);
        int p, idx;
        p = e / d;
        if (p == 0) begin
            x = HT - 1;
            y = VT - 1;
        end else begin
            idx = (p - 1) % (HT * VT);
            x = idx % HT;
            y = idx / HT;
        end
    endfunction

    function automatic exp_t model(input int e, input int d, input bit pol);
        exp_t r;
        int xs, ys, es;
        raster_pos(e, d, r.x, r.y);
`ifdef VGA_TIMING_ALIGN_EN
        es = (e > 0) ? e - 1 : 0;
`else
        es = e;
`endif
        raster_pos(es, d, xs, ys);
        r.tick = (e > 0) && (e % d == 0);
        r.ls   = r.tick && (r.x == 0);
        r.fs   = r.ls && (r.y == 0);
        r.hs   = (xs >= HA + HF && xs < HA + HF + HS) ? pol : !pol;
        r.vs   = (ys >= VA + VF && ys < VA + VF + VS) ? pol : !pol;
        r.av   = (xs < HA) && (ys < VA);
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: count clocks since reset release; clr changes only 2 time units after an edge.
    always @(posedge clk) begin
        bit clr_at_edge;
        clr_at_edge = clr;
        if (!clr_at_edge) n++;
        #3;
        if (clr) n = 0;
        qa.push_back(model(n, DA, PA));
        qb.push_back(model(n, DB, PB));
    end

    always @(negedge clk) begin
        exp_t ea, eb;
        if (qa.size() > 0 && qb.size() > 0) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            pops++;
            chk("a_x", int'(xa), ea.x);
            chk("a_y", int'(ya), ea.y);
            chk("a_hsync", int'(hsa), int'(ea.hs));
            chk("a_vsync", int'(vsa), int'(ea.vs));
            chk("a_active", int'(ava), int'(ea.av));
            chk("a_tick", int'(tka), int'(ea.tick));
            chk("a_line_start", int'(lsa), int'(ea.ls));
            chk("a_frame_start", int'(fsa), int'(ea.fs));
            chk("b_x", int'(xb), eb.x);
            chk("b_y", int'(yb), eb.y);
            chk("b_hsync", int'(hsb), int'(eb.hs));
            chk("b_vsync", int'(vsb), int'(eb.vs));
            chk("b_active", int'(avb), int'(eb.av));
            chk("b_tick", int'(tkb), int'(eb.tick));
            chk("b_line_start", int'(lsb), int'(eb.ls));
            chk("b_frame_start", int'(fsb), int'(eb.fs));
        end
    end

    task automatic pulse_reset(input int cycles);
        @(posedge clk);
        #2 clr = 1'b1;
        repeat (cycles) @(posedge clk);
        #2 clr = 1'b0;
    endtask

    initial begin
        #1 clr = 1'b1;
        repeat (3) @(posedge clk);
        #2 clr = 1'b0;
        for (int i = 0; i < N_CYCLES; i++) begin
            @(posedge clk);
            if (i == 1700) begin
                pulse_reset(1);
            end else if ($urandom_range(0, 699) == 0) begin
                pulse_reset(int'($urandom_range(1, 4)));
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("monitor_pops", int'(pops >= N_CYCLES), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
